fwd_pipe_ctrl: RTL

// - Forwarding source for the EX stage. Tracks the EX, MEM and WB pipeline slots.
// - Produces registered select codes for the two mux3_1 operand muxes (in_1=regfile, in_2=MEM data, in_3=WB data).
// - Owns the MEM and WB result registers that drive those mux data inputs and the regfile write port.

---
 rtl/fwd_pipe_ctrl_pkg.sv | 31 +++
 rtl/fwd_pipe_ctrl_if.sv | 32 +++
 rtl/fwd_pipe_ctrl_sel_cmp.sv | 28 ++
 rtl/fwd_pipe_ctrl.sv | 79 +++++++
 4 files changed

// File: rtl/fwd_pipe_ctrl_pkg.sv
// Shared types and constants for the EX-stage forwarding controller.
package fwd_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // mux3_1 select codes: in_1 = regfile, in_2 = MEM data, in_3 = WB data
  localparam logic [1:0] FWD_SEL_RF  = 2'b00;
  localparam logic [1:0] FWD_SEL_MEM = 2'b01;
  localparam logic [1:0] FWD_SEL_WB  = 2'b10;

  // Result slot carried through MEM and WB
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic [XLEN-1:0]       data;
  } slot_t;

  // EX slot: sources are needed for forwarding, the data is not yet known
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
  } ex_slot_t;

  localparam slot_t    SLOT_BUBBLE = '{rd: {REG_ADDR_W{1'b0}}, we: 1'b0, data: {XLEN{1'b0}}};
  localparam ex_slot_t EX_BUBBLE   = '{rs1: {REG_ADDR_W{1'b0}}, rs2: {REG_ADDR_W{1'b0}},
                                       rd: {REG_ADDR_W{1'b0}}, we: 1'b0};

endpackage

// File: rtl/fwd_pipe_ctrl_if.sv
// Pipeline-side bundle of the forwarding controller: ID/EX inputs, mux selects and result slots.
interface fwd_pipe_ctrl_if;
  import fwd_pkg::*;

  logic                  stall;
  logic                  flush;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_we;
  logic [XLEN-1:0]       ex_result;
  logic [1:0]            sel_a;
  logic [1:0]            sel_b;
  logic [XLEN-1:0]       mem_data;
  logic [XLEN-1:0]       wb_data;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_we;

  // Pipeline datapath side
  modport master (
    output stall, flush, id_valid, id_rs1, id_rs2, id_rd, id_we, ex_result,
    input  sel_a, sel_b, mem_data, wb_data, wb_rd, wb_we
  );

  // Forwarding controller side
  modport slave (
    input  stall, flush, id_valid, id_rs1, id_rs2, id_rd, id_we, ex_result,
    output sel_a, sel_b, mem_data, wb_data, wb_rd, wb_we
  );

endinterface

// File: rtl/fwd_pipe_ctrl_sel_cmp.sv
// Per-operand forwarding compare: youngest matching producer wins, x0 is never forwarded.
module fwd_sel_cmp
  import fwd_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] s_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_we_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_we_i,
  output logic [1:0]            sel_o
);

  logic s_nonzero_s;
  assign s_nonzero_s = (s_i != {REG_ADDR_W{1'b0}});

  // Priority compare: MEM producer before WB producer, otherwise regfile
  always_comb begin
    sel_o = FWD_SEL_RF;
    if (s_nonzero_s && mem_we_i && (mem_rd_i == s_i)) begin
      sel_o = FWD_SEL_MEM;
    end else if (s_nonzero_s && wb_we_i && (wb_rd_i == s_i)) begin
      sel_o = FWD_SEL_WB;
    end else begin
      sel_o = FWD_SEL_RF;
    end
  end

endmodule

// File: rtl/fwd_pipe_ctrl.sv
// EX-stage forwarding controller: EX/MEM/WB slot registers and registered mux3_1 selects.
// Selects are computed from the post-edge slot contents so they line up with the EX occupant.
module fwd_pipe_ctrl
  import fwd_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  fwd_pipe_ctrl_if.slave  bus
);

  ex_slot_t   ex_q,  ex_d;
  slot_t      mem_q, mem_d;
  slot_t      wb_q,  wb_d;
  logic [1:0] sel_a_q, sel_a_d;
  logic [1:0] sel_b_q, sel_b_d;

  // Slot next-state: flush bubbles EX (its occupant still retires), stall holds EX and bubbles MEM
  always_comb begin
    ex_d  = ex_q;
    mem_d = SLOT_BUBBLE;
    wb_d  = mem_q;
    if (bus.flush) begin
      ex_d  = EX_BUBBLE;
      mem_d = '{rd: ex_q.rd, we: ex_q.we, data: bus.ex_result};
    end else if (bus.stall) begin
      ex_d  = ex_q;
      mem_d = SLOT_BUBBLE;
    end else begin
      ex_d.rs1 = bus.id_rs1;
      ex_d.rs2 = bus.id_rs2;
      ex_d.rd  = bus.id_rd;
      ex_d.we  = bus.id_valid & bus.id_we;
      mem_d    = '{rd: ex_q.rd, we: ex_q.we, data: bus.ex_result};
    end
  end

  fwd_sel_cmp u_cmp_a (
    .s_i      (ex_d.rs1),
    .mem_rd_i (mem_d.rd),
    .mem_we_i (mem_d.we),
    .wb_rd_i  (wb_d.rd),
    .wb_we_i  (wb_d.we),
    .sel_o    (sel_a_d)
  );

  fwd_sel_cmp u_cmp_b (
    .s_i      (ex_d.rs2),
    .mem_rd_i (mem_d.rd),
    .mem_we_i (mem_d.we),
    .wb_rd_i  (wb_d.rd),
    .wb_we_i  (wb_d.we),
    .sel_o    (sel_b_d)
  );

  // Slot and select registers, cleared immediately by reset so no partial writeback survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= EX_BUBBLE;
      mem_q   <= SLOT_BUBBLE;
      wb_q    <= SLOT_BUBBLE;
      sel_a_q <= FWD_SEL_RF;
      sel_b_q <= FWD_SEL_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign bus.sel_a    = sel_a_q;
  assign bus.sel_b    = sel_b_q;
  assign bus.mem_data = mem_q.data;
  assign bus.wb_data  = wb_q.data;
  assign bus.wb_rd    = wb_q.rd;
  assign bus.wb_we    = wb_q.we;

endmodule
